// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared geometry constants and collision FSM encoding
package game_pkg;

    localparam int POS_W = 19;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    // Box sizes travel on 7-bit buses; the largest default size is 36 px
    localparam int SZ_W  = 7;

    localparam int DEF_ENEMY_W  = 36;
    localparam int DEF_ENEMY_H  = 24;
    localparam int DEF_PLAYER_W = 24;
    localparam int DEF_PLAYER_H = 36;
    localparam int DEF_BULLET_W = 4;
    localparam int DEF_BULLET_H = 16;
    localparam int DEF_PLAYER_Y = 372;

    // Off-screen parking spot for dead objects
    localparam logic [POS_W-1:0] NONE_POS = {10'd720, 9'd500};

    typedef enum logic [2:0] {
        IDLE,
        SCAN_PB_EB,
        SCAN_PB_EN,
        SCAN_EB_PL,
        PUBLISH
    } scanState_t;

    function automatic logic [X_W-1:0] posX(input logic [POS_W-1:0] pos);
        return pos[POS_W-1:Y_W];
    endfunction

    function automatic logic [Y_W-1:0] posY(input logic [POS_W-1:0] pos);
        return pos[Y_W-1:0];
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// rtl/aabb_overlap.sv - strict axis-aligned box overlap test with widened sums
module aabb_overlap
    import game_pkg::*;
(
    input  logic [X_W-1:0]  aX,
    input  logic [Y_W-1:0]  aY,
    input  logic [SZ_W-1:0] aW,
    input  logic [SZ_W-1:0] aH,
    input  logic [X_W-1:0]  bX,
    input  logic [Y_W-1:0]  bY,
    input  logic [SZ_W-1:0] bW,
    input  logic [SZ_W-1:0] bH,
    output logic            overlap
);

    logic [X_W:0] aLeft, aRight, bLeft, bRight;
    logic [Y_W:0] aTop, aBot, bTop, bBot;

    // Edges carry one extra bit so x+w and y+h never wrap; touching edges do not collide
    always_comb begin
        aLeft   = {1'b0, aX};
        bLeft   = {1'b0, bX};
        aRight  = {1'b0, aX} + {{(X_W+1-SZ_W){1'b0}}, aW};
        bRight  = {1'b0, bX} + {{(X_W+1-SZ_W){1'b0}}, bW};
        aTop    = {1'b0, aY};
        bTop    = {1'b0, bY};
        aBot    = {1'b0, aY} + {{(Y_W+1-SZ_W){1'b0}}, aH};
        bBot    = {1'b0, bY} + {{(Y_W+1-SZ_W){1'b0}}, bH};
        overlap = (aLeft < bRight) && (bLeft < aRight) && (aTop < bBot) && (bTop < aBot);
    end

endmodule

// File: rtl/collision_engine.sv
// rtl/collision_engine.sv - time-multiplexed per-frame collision scan with lives and kill tracking
module collision_engine
    import game_pkg::*;
#(
    parameter int N_ENEMY      = 3,
    parameter int N_EBULLET    = 3,
    parameter int N_PBULLET    = 3,
    parameter int ENEMY_W      = DEF_ENEMY_W,
    parameter int ENEMY_H      = DEF_ENEMY_H,
    parameter int PLAYER_W     = DEF_PLAYER_W,
    parameter int PLAYER_H     = DEF_PLAYER_H,
    parameter int BULLET_W     = DEF_BULLET_W,
    parameter int BULLET_H     = DEF_BULLET_H,
    parameter int PLAYER_Y     = DEF_PLAYER_Y,
    parameter int PLAYER_LIVES = 3,
    parameter int LIVES_W      = 2
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_Start,
    input  logic                       i_LivesReload,
    input  logic [N_ENEMY-1:0]         i_EnemyAlive,
    input  logic [POS_W*N_ENEMY-1:0]   i_EnemyPos,
    input  logic [N_EBULLET-1:0]       i_EBulletAlive,
    input  logic [POS_W*N_EBULLET-1:0] i_EBulletPos,
    input  logic [N_PBULLET-1:0]       i_PBulletAlive,
    input  logic [POS_W*N_PBULLET-1:0] i_PBulletPos,
    input  logic [X_W-1:0]             i_PlayerX,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic [N_ENEMY-1:0]         o_EnemyHit,
    output logic [N_EBULLET-1:0]       o_EBulletHit,
    output logic [N_PBULLET-1:0]       o_PBulletHit,
    output logic                       o_PlayerHit,
    output logic [LIVES_W-1:0]         o_Lives,
    output logic                       o_GameOver,
    output logic [7:0]                 o_KillCount
);

    localparam int MAX_A     = (N_ENEMY > N_EBULLET) ? N_ENEMY : N_EBULLET;
    localparam int MAX_SLOTS = (MAX_A > N_PBULLET) ? MAX_A : N_PBULLET;
    localparam int IDX_W     = $clog2(MAX_SLOTS + 1);

    localparam logic [IDX_W-1:0]   PB_LAST   = IDX_W'(N_PBULLET - 1);
    localparam logic [IDX_W-1:0]   EB_LAST   = IDX_W'(N_EBULLET - 1);
    localparam logic [IDX_W-1:0]   EN_LAST   = IDX_W'(N_ENEMY - 1);
    localparam logic [SZ_W-1:0]    EN_W_S    = SZ_W'(ENEMY_W);
    localparam logic [SZ_W-1:0]    EN_H_S    = SZ_W'(ENEMY_H);
    localparam logic [SZ_W-1:0]    PL_W_S    = SZ_W'(PLAYER_W);
    localparam logic [SZ_W-1:0]    PL_H_S    = SZ_W'(PLAYER_H);
    localparam logic [SZ_W-1:0]    BU_W_S    = SZ_W'(BULLET_W);
    localparam logic [SZ_W-1:0]    BU_H_S    = SZ_W'(BULLET_H);
    localparam logic [Y_W-1:0]     PL_Y      = Y_W'(PLAYER_Y);
    localparam logic [LIVES_W-1:0] LIVES_MAX = LIVES_W'(PLAYER_LIVES);

    scanState_t state, stateNext;
    logic [IDX_W-1:0] outerIdx, innerIdx;

    logic [POS_W-1:0]     enPos [N_ENEMY];
    logic [POS_W-1:0]     ebPos [N_EBULLET];
    logic [POS_W-1:0]     pbPos [N_PBULLET];
    logic [N_ENEMY-1:0]   enAlive, enAcc;
    logic [N_EBULLET-1:0] ebAlive, ebAcc;
    logic [N_PBULLET-1:0] pbAlive, pbAcc;
    logic [X_W-1:0]       snapPlayerX;
    logic                 snapPlAlive, plAcc;

    logic [POS_W-1:0] aPos, bPos;
    logic [SZ_W-1:0]  aW, aH, bW, bH;
    logic             pairValid, pairOverlap, pairHit;
    logic [8:0]       killSum;

    assign o_Busy     = (state != IDLE);
    assign o_GameOver = (o_Lives == '0);
    assign pairHit    = pairValid & pairOverlap;

    // State register; reset aborts any scan in flight
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) state <= IDLE;
        else        state <= stateNext;
    end

    // Phase sequencing: each scan phase ends on its last pair
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:       if (i_Start) stateNext = SCAN_PB_EB;
            SCAN_PB_EB: if (outerIdx == PB_LAST && innerIdx == EB_LAST) stateNext = SCAN_PB_EN;
            SCAN_PB_EN: if (outerIdx == PB_LAST && innerIdx == EN_LAST) stateNext = SCAN_EB_PL;
            SCAN_EB_PL: if (innerIdx == EB_LAST) stateNext = PUBLISH;
            PUBLISH:    stateNext = IDLE;
            default:    stateNext = IDLE;
        endcase
    end

    // Pair indices: pb is the outer loop, the other object the inner loop
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            outerIdx <= '0;
            innerIdx <= '0;
        end else begin
            case (state)
                SCAN_PB_EB, SCAN_PB_EN: begin
                    if (innerIdx == ((state == SCAN_PB_EB) ? EB_LAST : EN_LAST)) begin
                        innerIdx <= '0;
                        outerIdx <= (outerIdx == PB_LAST) ? '0 : outerIdx + IDX_W'(1);
                    end else begin
                        innerIdx <= innerIdx + IDX_W'(1);
                    end
                end
                SCAN_EB_PL: innerIdx <= (innerIdx == EB_LAST) ? '0 : innerIdx + IDX_W'(1);
                default: begin
                    outerIdx <= '0;
                    innerIdx <= '0;
                end
            endcase
        end
    end

    // Steer the current pair and its box sizes into the single comparator
    always_comb begin
        aPos      = NONE_POS;
        bPos      = NONE_POS;
        aW        = BU_W_S;
        aH        = BU_H_S;
        bW        = BU_W_S;
        bH        = BU_H_S;
        pairValid = 1'b0;
        case (state)
            SCAN_PB_EB: begin
                aPos      = pbPos[outerIdx];
                bPos      = ebPos[innerIdx];
                pairValid = pbAlive[outerIdx] & ebAlive[innerIdx];
            end
            SCAN_PB_EN: begin
                aPos      = pbPos[outerIdx];
                bPos      = enPos[innerIdx];
                bW        = EN_W_S;
                bH        = EN_H_S;
                pairValid = pbAlive[outerIdx] & enAlive[innerIdx];
            end
            SCAN_EB_PL: begin
                aPos      = ebPos[innerIdx];
                bPos      = {snapPlayerX, PL_Y};
                bW        = PL_W_S;
                bH        = PL_H_S;
                pairValid = ebAlive[innerIdx] & snapPlAlive;
            end
            default: ;
        endcase
    end

    aabb_overlap u_aabb (
        .aX      (posX(aPos)),
        .aY      (posY(aPos)),
        .aW      (aW),
        .aH      (aH),
        .bX      (posX(bPos)),
        .bY      (posY(bPos)),
        .bW      (bW),
        .bH      (bH),
        .overlap (pairOverlap)
    );

    // Snapshot the world on start, then accumulate hits pair by pair
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            for (int k = 0; k < N_ENEMY; k++)   enPos[k] <= NONE_POS;
            for (int k = 0; k < N_EBULLET; k++) ebPos[k] <= NONE_POS;
            for (int k = 0; k < N_PBULLET; k++) pbPos[k] <= NONE_POS;
            enAlive     <= '0;
            ebAlive     <= '0;
            pbAlive     <= '0;
            snapPlayerX <= '0;
            snapPlAlive <= 1'b0;
            enAcc       <= '0;
            ebAcc       <= '0;
            pbAcc       <= '0;
            plAcc       <= 1'b0;
        end else if (state == IDLE && i_Start) begin
            for (int k = 0; k < N_ENEMY; k++)   enPos[k] <= i_EnemyPos[k*POS_W +: POS_W];
            for (int k = 0; k < N_EBULLET; k++) ebPos[k] <= i_EBulletPos[k*POS_W +: POS_W];
            for (int k = 0; k < N_PBULLET; k++) pbPos[k] <= i_PBulletPos[k*POS_W +: POS_W];
            enAlive     <= i_EnemyAlive;
            ebAlive     <= i_EBulletAlive;
            pbAlive     <= i_PBulletAlive;
            snapPlayerX <= i_PlayerX;
            // A simultaneous reload means the scan sees a living player
            snapPlAlive <= i_LivesReload ? (LIVES_MAX != '0) : (o_Lives != '0);
            enAcc       <= '0;
            ebAcc       <= '0;
            pbAcc       <= '0;
            plAcc       <= 1'b0;
        end else if (pairHit) begin
            case (state)
                SCAN_PB_EB: begin
                    pbAcc[outerIdx] <= 1'b1;
                    ebAcc[innerIdx] <= 1'b1;
                end
                SCAN_PB_EN: begin
                    pbAcc[outerIdx] <= 1'b1;
                    enAcc[innerIdx] <= 1'b1;
                end
                SCAN_EB_PL: begin
                    ebAcc[innerIdx] <= 1'b1;
                    plAcc           <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Kill count plus this scan's enemy hits, before saturation
    always_comb begin
        killSum = {1'b0, o_KillCount};
        for (int k = 0; k < N_ENEMY; k++) killSum = killSum + {8'd0, enAcc[k]};
    end

    // Publish results, count kills and take at most one life per scan
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            o_Done       <= 1'b0;
            o_EnemyHit   <= '0;
            o_EBulletHit <= '0;
            o_PBulletHit <= '0;
            o_PlayerHit  <= 1'b0;
            o_Lives      <= LIVES_MAX;
            o_KillCount  <= '0;
        end else begin
            o_Done <= (state == PUBLISH);
            if (state == IDLE && i_LivesReload) begin
                o_Lives     <= LIVES_MAX;
                o_KillCount <= '0;
            end
            if (state == PUBLISH) begin
                o_EnemyHit   <= enAcc;
                o_EBulletHit <= ebAcc;
                o_PBulletHit <= pbAcc;
                o_PlayerHit  <= plAcc;
                if (plAcc && o_Lives != '0) o_Lives <= o_Lives - LIVES_W'(1);
                o_KillCount  <= (killSum > 9'd255) ? 8'hFF : killSum[7:0];
            end
        end
    end

endmodule

// File: tb/tb_collision_engine.sv
// tb/tb_collision_engine.sv - directed vector bench for collision_engine
module tb_collision_engine;
    import game_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        reload;
    logic [2:0]  enAlive, ebAlive, pbAlive;
    logic [56:0] enPos, ebPos, pbPos;
    logic [9:0]  playerX;
    logic        busy, done, plHit, gameOver;
    logic [2:0]  enHit, ebHit, pbHit;
    logic [1:0]  lives;
    logic [7:0]  kills;

    int nChecks = 0;
    int nFails  = 0;

    collision_engine dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Start        (start),
        .i_LivesReload  (reload),
        .i_EnemyAlive   (enAlive),
        .i_EnemyPos     (enPos),
        .i_EBulletAlive (ebAlive),
        .i_EBulletPos   (ebPos),
        .i_PBulletAlive (pbAlive),
        .i_PBulletPos   (pbPos),
        .i_PlayerX      (playerX),
        .o_Busy         (busy),
        .o_Done         (done),
        .o_EnemyHit     (enHit),
        .o_EBulletHit   (ebHit),
        .o_PBulletHit   (pbHit),
        .o_PlayerHit    (plHit),
        .o_Lives        (lives),
        .o_GameOver     (gameOver),
        .o_KillCount    (kills)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rl;
        logic [2:0]  enA, ebA, pbA;
        logic [56:0] enP, ebP, pbP;
        logic [9:0]  px;
        logic [2:0]  xEn, xEb, xPb;
        logic        xPl;
        logic [1:0]  xLives;
        logic        xGo;
        logic [7:0]  xKill;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [18:0] p(input int x, input int y);
        return {10'(x), 9'(y)};
    endfunction

    function automatic vec_t mk(input logic rl,
                                input logic [2:0] enA, input logic [56:0] enP,
                                input logic [2:0] ebA, input logic [56:0] ebP,
                                input logic [2:0] pbA, input logic [56:0] pbP,
                                input logic [9:0] px,
                                input logic [2:0] xEn, input logic [2:0] xEb, input logic [2:0] xPb,
                                input logic xPl, input logic [1:0] xLives, input logic xGo,
                                input logic [7:0] xKill);
        vec_t v;
        v.rl = rl; v.enA = enA; v.enP = enP; v.ebA = ebA; v.ebP = ebP;
        v.pbA = pbA; v.pbP = pbP; v.px = px;
        v.xEn = xEn; v.xEb = xEb; v.xPb = xPb; v.xPl = xPl;
        v.xLives = xLives; v.xGo = xGo; v.xKill = xKill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyInputs(input vec_t v);
        enAlive = v.enA; enPos = v.enP;
        ebAlive = v.ebA; ebPos = v.ebP;
        pbAlive = v.pbA; pbPos = v.pbP;
        playerX = v.px;
    endtask

    // Start a scan and wait (bounded) for o_Done; doneEdge is 0 if it never came
    task automatic runScan(input logic rl, output int doneEdge, output logic busy1,
                           output logic busy21, output logic busyDone);
        doneEdge = 0; busy1 = 1'b0; busy21 = 1'b0; busyDone = 1'b1;
        start = 1'b1; reload = rl;
        @(posedge clk); #1;
        start = 1'b0; reload = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 1)  busy1  = busy;
            if (e == 21) busy21 = busy;
            if (done) begin
                doneEdge = e;
                busyDone = busy;
                break;
            end
        end
    endtask

    task automatic checkOutputs(input string tag, input logic [2:0] xEn, input logic [2:0] xEb,
                                input logic [2:0] xPb, input logic xPl, input logic [1:0] xLives,
                                input logic xGo, input logic [7:0] xKill);
        check({tag, "_enHit"}, enHit, xEn);
        check({tag, "_ebHit"}, ebHit, xEb);
        check({tag, "_pbHit"}, pbHit, xPb);
        check({tag, "_plHit"}, plHit, xPl);
        check({tag, "_lives"}, lives, xLives);
        check({tag, "_gameOver"}, gameOver, xGo);
        check({tag, "_kills"}, kills, xKill);
    endtask

    initial begin
        logic [18:0] nn;
        logic [56:0] n3;
        vec_t hs;
        vec_t dead;
        int doneEdge, doneCount;
        logic b1, b21, bd;

        nn = NONE_POS;
        n3 = {nn, nn, nn};

        //            rl    enA    enP                        ebA    ebP                                        pbA    pbP                                    px    xEn    xEb    xPb    xPl lives go kill
        vecs[0] = mk(1'b0, 3'b000, n3,                       3'b001, {nn, nn, p(200,360)},                     3'b000, n3,                                    202, 3'b000, 3'b001, 3'b000, 1, 2, 0, 0);
        vecs[1] = mk(1'b0, 3'b100, {p(300,100), nn, nn},     3'b100, {p(300,250), nn, nn},                     3'b110, {p(320,120), p(302,260), nn},          0,   3'b100, 3'b100, 3'b110, 0, 2, 0, 1);
        vecs[2] = mk(1'b0, 3'b100, {p(300,100), nn, nn},     3'b000, n3,                                       3'b001, {nn, nn, p(336,120)},                  0,   3'b000, 3'b000, 3'b000, 0, 2, 0, 1);
        vecs[3] = mk(1'b0, 3'b000, {p(300,100), nn, nn},     3'b000, n3,                                       3'b001, {nn, nn, p(320,120)},                  0,   3'b000, 3'b000, 3'b000, 0, 2, 0, 1);
        vecs[4] = mk(1'b0, 3'b001, {nn, nn, p(1000,100)},    3'b000, n3,                                       3'b001, {nn, nn, p(1010,110)},                 0,   3'b001, 3'b000, 3'b001, 0, 2, 0, 2);
        vecs[5] = mk(1'b0, 3'b000, n3,                       3'b001, {nn, nn, p(100,500)},                     3'b001, {nn, nn, p(101,505)},                  0,   3'b000, 3'b001, 3'b001, 0, 2, 0, 2);
        vecs[6] = mk(1'b1, 3'b000, n3,                       3'b111, {p(210,380), p(205,370), p(200,360)},     3'b000, n3,                                    202, 3'b000, 3'b111, 3'b000, 1, 2, 0, 0);
        vecs[7] = mk(1'b0, 3'b000, n3,                       3'b111, {p(210,380), p(205,370), p(200,360)},     3'b000, n3,                                    202, 3'b000, 3'b111, 3'b000, 1, 1, 0, 0);
        vecs[8] = mk(1'b0, 3'b000, n3,                       3'b111, {p(210,380), p(205,370), p(200,360)},     3'b000, n3,                                    202, 3'b000, 3'b111, 3'b000, 1, 0, 1, 0);
        vecs[9] = mk(1'b0, 3'b000, n3,                       3'b111, {p(210,380), p(205,370), p(200,360)},     3'b000, n3,                                    202, 3'b000, 3'b000, 3'b000, 0, 0, 1, 0);

        hs   = mk(1'b0, 3'b100, {p(300,100), nn, nn}, 3'b001, {nn, nn, p(200,360)}, 3'b100, {p(320,120), nn, nn},
                  202, 3'b100, 3'b001, 3'b100, 1, 2, 0, 1);
        dead = mk(1'b0, 3'b000, n3, 3'b000, n3, 3'b000, n3, 600, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);

        rst = 1'b0; start = 1'b0; reload = 1'b0;
        applyInputs(dead);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        checkOutputs("rst", 3'b000, 3'b000, 3'b000, 0, 2'd3, 0, 8'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            applyInputs(vecs[i]);
            runScan(vecs[i].rl, doneEdge, b1, b21, bd);
            check($sformatf("v%0d_doneEdge", i), doneEdge, 22);
            check($sformatf("v%0d_busyEdge1", i), b1, 1);
            check($sformatf("v%0d_busyPublish", i), b21, 1);
            check($sformatf("v%0d_busyAtDone", i), bd, 0);
            checkOutputs($sformatf("v%0d", i), vecs[i].xEn, vecs[i].xEb, vecs[i].xPb,
                         vecs[i].xPl, vecs[i].xLives, vecs[i].xGo, vecs[i].xKill);
        end

        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check("reload_lives", lives, 3);
        check("reload_gameOver", gameOver, 0);
        check("reload_kills", kills, 0);

        // Restart during a scan must be ignored; mid-scan input changes must not leak in
        applyInputs(hs);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        doneCount = 0; doneEdge = 0;
        for (int e = 1; e <= 60; e++) begin
            if (e == 5) begin
                start = 1'b1;
                applyInputs(dead);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                doneCount++;
                if (doneEdge == 0) doneEdge = e;
            end
        end
        start = 1'b0;
        check("hs_doneCount", doneCount, 1);
        check("hs_doneEdge", doneEdge, 22);
        checkOutputs("hs", hs.xEn, hs.xEb, hs.xPb, hs.xPl, hs.xLives, hs.xGo, hs.xKill);

        // Reset in the middle of a scan
        applyInputs(hs);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        checkOutputs("midrst", 3'b000, 3'b000, 3'b000, 0, 2'd3, 0, 8'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        doneCount = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (done) doneCount++;
        end
        check("midrst_noDone", doneCount, 0);
        check("midrst_idle", busy, 0);

        applyInputs(hs);
        runScan(1'b0, doneEdge, b1, b21, bd);
        check("post_doneEdge", doneEdge, 22);
        checkOutputs("post", hs.xEn, hs.xEb, hs.xPb, hs.xPl, hs.xLives, hs.xGo, hs.xKill);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/collision_engine.md
Name: collision_engine

Overview:
- Time-multiplexed, parametrised collision engine for the shooter game.
- On each frame-start pulse it snapshots all object positions and alive masks, then tests one object pair per clock through a single AABB comparator.
- When the scan ends it publishes registered hit masks and updates a player-lives counter and a kill counter.
- Sits between the object-movement logic and the game-state FSM (IDLE/PLAYING/VICTORY/DEFEAT), once per video frame.

Parameters:
- N_ENEMY, 3: number of enemy slots.
- N_EBULLET, 3: number of enemy-bullet slots.
- N_PBULLET, 3: number of player-bullet slots.
- ENEMY_W / ENEMY_H, 36 / 24: enemy box size (px).
- PLAYER_W / PLAYER_H, 24 / 36: player box size (px).
- BULLET_W / BULLET_H, 4 / 16: bullet box size (px), shared by both bullet types.
- PLAYER_Y, 372: fixed player top-left y.
- PLAYER_LIVES, 3: lives loaded at reset and on i_LivesReload.
- LIVES_W, 2: width of o_Lives.

Ports:
- i_Clk  in  1  clock.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Start  in  1  frame-start request; sampled only in IDLE.
- i_LivesReload  in  1  synchronous reload of lives and kill count; honoured only in IDLE.
- i_EnemyAlive  in  N_ENEMY  per-slot alive mask.
- i_EnemyPos  in  19*N_ENEMY  packed {x[9:0], y[8:0]}; slot k occupies bits [19k+18:19k].
- i_EBulletAlive  in  N_EBULLET  alive mask.
- i_EBulletPos  in  19*N_EBULLET  packed, same layout.
- i_PBulletAlive  in  N_PBULLET  alive mask.
- i_PBulletPos  in  19*N_PBULLET  packed, same layout.
- i_PlayerX  in  10  player top-left x.
- o_Busy  out  1  scan in progress.
- o_Done  out  1  one-cycle pulse; hit masks are valid from this cycle.
- o_EnemyHit  out  N_ENEMY  enemies hit during the last scan.
- o_EBulletHit  out  N_EBULLET  enemy bullets to destroy.
- o_PBulletHit  out  N_PBULLET  player bullets to destroy.
- o_PlayerHit  out  1  player hit during the last scan.
- o_Lives  out  LIVES_W  remaining lives.
- o_GameOver  out  1  high while o_Lives == 0.
- o_KillCount  out  8  saturating count of enemies hit.

Behaviour:
- Reset values: all masks 0, o_Busy 0, o_Done 0, o_Lives = PLAYER_LIVES, o_GameOver 0, o_KillCount 0, FSM in IDLE. Reset asserted mid-scan aborts the scan; no partial results are published.
- FSM states: IDLE -> SCAN_PB_EB -> SCAN_PB_EN -> SCAN_EB_PL -> PUBLISH -> IDLE.
- IDLE, i_Start=1: latch all inputs into snapshot registers, clear accumulators, enter SCAN_PB_EB. Inputs may change freely afterwards.
- SCAN_PB_EB: one (pb, eb) pair per cycle, pb outer loop, eb inner loop. A hit sets both pbAcc[pb] and ebAcc[eb].
- SCAN_PB_EN: one (pb, en) pair per cycle. A hit sets pbAcc[pb] and enAcc[en].
- SCAN_EB_PL: one eb per cycle against the player box {i_PlayerX, PLAYER_Y}. A hit sets ebAcc[eb] and plAcc.
- A pair counts only if both snapshot alive bits are 1. The player counts as alive while lives > 0.
- Overlap rule: strict, so edges that only touch do not collide. overlap = (Ax < Bx+Bw) & (Bx < Ax+Aw) & (Ay < By+Bh) & (By < Ay+Ah).
- All sums are computed at 11 bits (x) and 10 bits (y); there is no wrap-around, so x=1020 with w=36 gives 1056, not 32.
- Dead-object parking position {720, 500} falls outside the screen and is legal.
- Scan length N = N_PBULLET*N_EBULLET + N_PBULLET*N_ENEMY + N_EBULLET cycles; the default is 21. Counter widths are $clog2-sized from the parameters.
- PUBLISH (one cycle): copy accumulators to the o_*Hit registers and pulse o_Done. The hit masks hold until the next PUBLISH.
- Lives: if plAcc and o_Lives > 0, decrement o_Lives by 1, at most once per scan regardless of how many bullets hit. Saturate at 0.
- o_KillCount += popcount(enAcc), saturating at 255.
- Timing: o_Busy is high from the cycle after the i_Start edge through the PUBLISH cycle inclusive. o_Done is high on clock edge N+1 after the start edge (edge 22 by default).
- i_Start while o_Busy is ignored; it is not queued.
- i_Start and i_LivesReload together in IDLE: the reload applies first, then the scan starts using the reloaded lives.

Decomposition:
- Shared package game_pkg: POS_W=19, X_W=10, Y_W=9, object size constants, PLAYER_Y, NONE_POS={720,500}, and the FSM state encoding.
- One sub-module, aabb_overlap: combinational, with 11/10-bit width-safe compare, parameter-free sizes as inputs.
- Operand muxing and the FSM stay in collision_engine.

Test Plan:
- Player hit: EB0 at (200,360) alive, i_PlayerX=202, all else dead, start -> o_Done on edge 22, o_PlayerHit=1, o_EBulletHit=001, o_Lives 3->2, other masks 0.
- Bullet vs bullet: PB1 at (302,260), EB2 at (300,250); bullet vs enemy: PB2 at (320,120), EN2 at (300,100) -> o_PBulletHit=110, o_EBulletHit=100, o_EnemyHit=100, o_KillCount=1.
- Edge touch and dead mask: PB0 at (336,120) vs EN2 (300,100) -> no hit. PB0 at (320,120) with EN2 alive=0 -> no hit, o_KillCount unchanged.
- Lives saturation: three EBs overlapping the player for 4 consecutive scans -> o_Lives 3,2,1,0,0; o_GameOver=1 after the third scan; afterwards o_PlayerHit=0 because the player is dead. i_LivesReload -> o_Lives=3, o_GameOver=0.
- Handshake: pulse i_Start again 5 cycles into a scan -> ignored, exactly one o_Done. Change inputs mid-scan -> results reflect the snapshot.
- Reset mid-scan: drop i_Rst at scan cycle 10 -> all outputs return to reset values immediately, o_Done never pulses, next start yields a clean scan.
